// File: rtl/alu_pkg.sv
// Shared encodings for the 8-bit alu and the sequential multiplier FSM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  // Low three bits of alu_op select the operation.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SHL = 3'b100;

  // alu_op[4:3] holds (shift amount - 1), so 2'b00 means shift by one.
  localparam int ALU_SHAMT_LSB = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } mul_state_e;

  // Build a full 5-bit alu_op from an operation and its shift-amount field.
  function automatic logic [4:0] alu_opcode(input logic [2:0] op, input logic [1:0] shamt_m1);
    return {shamt_m1, op};
  endfunction

endpackage

// File: rtl/alu_mul_seq_if.sv
// Operand and result handshakes of the sequential multiplier.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the operand and the result side.
interface alu_mul_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       ovf;
  logic       busy;

  // Issuer/consumer side.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, ovf, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, ovf, busy
  );
endinterface

// File: rtl/alu.sv
// Combinational 8-bit alu: add, sub, and, or, left shift by 1..4.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module alu
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [4:0] alu_op,
  output logic [7:0] y
);

  logic [2:0] shamt;

  // Decode the operation; unused encodings return zero.
  always_comb begin
    y     = 8'd0;
    shamt = {1'b0, alu_op[ALU_SHAMT_LSB+1:ALU_SHAMT_LSB]} + 3'd1;
    case (alu_op[2:0])
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SHL: y = a << shamt;
      default: y = 8'd0;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add 8x8 multiplier returning (a*b) mod 256 plus an overflow flag.
// Latency: result valid in the 17th cycle after operand accept; 18-cycle issue interval.
// Backpressure: operands taken only in IDLE; result held in DONE until out_ready.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  alu_mul_seq_if.slave  io
);

  mul_state_e state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] mcand_q, mcand_d;
  logic [7:0] mplier_q, mplier_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ovf_r_q, ovf_r_d;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] alu_op;
  logic [7:0] alu_y;

  alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .y      (alu_y)
  );

  // Next-state, register updates and alu operand steering.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    ovf_r_d  = ovf_r_q;
    // IDLE and ADD both present acc + mcand; the result is ignored in IDLE.
    alu_a    = acc_q;
    alu_b    = mcand_q;
    alu_op   = alu_opcode(ALU_ADD, 2'b00);

    case (state_q)
      ST_IDLE: begin
        if (io.in_valid) begin
          acc_d    = 8'd0;
          mcand_d  = io.a;
          mplier_d = io.b;
          cnt_d    = 3'd0;
          ovf_r_d  = 1'b0;
          state_d  = ST_ADD;
        end
      end
      ST_ADD: begin
        if (mplier_q[0]) begin
          acc_d = alu_y;
          // A wrapped sum is smaller than the addend it started from.
          if (alu_y < acc_q) begin
            ovf_r_d = 1'b1;
          end
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        alu_a    = mcand_q;
        alu_b    = 8'd0;
        alu_op   = alu_opcode(ALU_SHL, 2'b00);
        mcand_d  = alu_y;
        mplier_d = mplier_q >> 1;
        // The bit leaving mcand would still be added if any multiplier bits remain.
        if (mcand_q[7] && ((mplier_q >> 1) != 8'd0)) begin
          ovf_r_d = 1'b1;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ADD;
        end
      end
      ST_DONE: begin
        if (io.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= 8'd0;
      mcand_q  <= 8'd0;
      mplier_q <= 8'd0;
      cnt_q    <= 3'd0;
      ovf_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      ovf_r_q  <= ovf_r_d;
    end
  end

  // Handshake outputs come from state alone; the result comes straight from flops.
  assign io.in_ready  = (state_q == ST_IDLE);
  assign io.out_valid = (state_q == ST_DONE);
  assign io.busy      = (state_q != ST_IDLE);
  assign io.product   = acc_q;
  assign io.ovf       = ovf_r_q;

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 8×8 unsigned multiplier controller that produces the low byte of the product by sequencing the existing 8-bit `alu` through shift-and-add iterations. It owns one `alu` instance and drives its operands and `alu_op` from a small FSM. It accepts operands over a valid/ready handshake and returns the product over a second valid/ready handshake. It sits beside the core datapath as the multi-cycle MUL execution unit.

## Interface
Parameters:
- none; data width is fixed at 8 bits to match `alu`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair `a`/`b` is valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  8  multiplicand.
- `b`  in  8  multiplier.
- `out_valid`  out  1  `product`/`ovf` are valid; held until accepted.
- `out_ready`  in  1  consumer accepts the result.
- `product`  out  8  (a*b) mod 256.
- `ovf`  out  1  true product ≥ 256.
- `busy`  out  1  high in ADD, SHIFT and DONE.

## Operation
- Internal registers: `acc`[7:0], `mcand`[7:0], `mplier`[7:0], `cnt`[2:0], `ovf_r`.
- FSM states: IDLE, ADD, SHIFT, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, load `acc`=0, `mcand`=a, `mplier`=b, `cnt`=0, `ovf_r`=0, and go to ADD.
- ADD: `alu` A=`acc`, B=`mcand`, `alu_op`=5'b00000. If `mplier[0]`, set `acc`=alu result, and set `ovf_r` if result < `acc` (unsigned wrap). Otherwise `acc` is unchanged. Go to SHIFT.
- SHIFT: `alu` A=`mcand`, B=0, `alu_op`=5'b00100 (shift left by 1). Update `mcand`=result and `mplier`=`mplier`>>1. Set `ovf_r` if `mcand[7]` && (`mplier`>>1)≠0, since a discarded bit would have contributed. Increment `cnt`. If `cnt`==7 (wraps to 0), go to DONE; else go to ADD.
- DONE: `out_valid`=1, `product`=`acc`, `ovf`=`ovf_r`. On `out_ready`, go to IDLE.
- In IDLE, the `alu` inputs are driven as in ADD; the result is unused.
- `in_valid` in any state other than IDLE is ignored: no capture and no side effect.
- All arithmetic is 8-bit and wraps modulo 256. `ovf` is the only record of lost bits.
- Always exactly 8 iterations; no early exit when `mplier` reaches 0.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `product`=0, `ovf`=0, all internal registers 0.
- Accept edge E0: ADD/SHIFT occupy the 16 cycles after E0. `out_valid` rises in the 17th cycle after E0.
- Result handshake:
  - `product` and `ovf` are stable while `out_valid`=1.
  - Transfer occurs on the edge with `out_valid`&&`out_ready`.
  - `in_ready` returns the cycle after that edge. There is no same-cycle result/accept overlap.
  - Minimum issue interval is 18 cycles.
- `out_ready` held high before DONE has no effect. DONE still lasts at least one cycle.
- `rst` asserted at any point, including mid-iteration or in DONE: immediate return to reset values. The pending result is discarded.
- `product` and `ovf` are registered outputs. `in_ready`, `out_valid` and `busy` are decoded from registered state only, with no input-to-output combinational path.

## Structure
- Shared package `alu_pkg`:
  - ALU op encodings: ADD=3'b000, SUB, AND, OR, SHIFT=3'b100.
  - Shift-amount field: `alu_op[4:3]`.
  - State enum: IDLE/ADD/SHIFT/DONE.
- Sub-module: one instance of the existing `alu`, named `u_alu`. All arithmetic goes through it; there are no separate adders or shifters in this block except the `mplier` right shift and the `cnt` increment.

## Test plan
- a=13, b=11, `out_ready`=1 → `out_valid` in the 17th cycle after accept; `product`=143 (0x8F), `ovf`=0; `in_ready` high the next cycle.
- a=255, b=255 → `product`=0x01, `ovf`=1. Also a=16, b=16 → `product`=0x00, `ovf`=1.
- a=0, b=200 and a=1, b=255 → `product`=0 / 255, `ovf`=0; both still take 17 cycles.
- Back-pressure: a=7, b=9, `out_ready` low for 5 cycles after `out_valid` → `product`=63 held constant. `in_valid` pulses with a=1, b=1 during busy/DONE are ignored. The next accepted op uses the new operands.
- Reset 8 cycles after accept of a=200, b=3 → all outputs at reset values the same cycle. The next op a=3, b=5 yields 15, `ovf`=0.
- Random sweep of 1000 pairs → `product`==(a*b)&8'hFF and `ovf`==((a*b)>255) for every pair.
